alu_writeback: RTL and testbench
================================

# alu_writeback

Writeback stage directly downstream of the 16-bit `alu`. It registers each ALU result together with its five flags (Z C F N L). It commits the result into a 16 × 16-bit register file and the selected flags into the processor status register (PSR). Two combinational read ports feed the ALU operand muxes. Compare-class operations (CMP, CMPU) update only the PSR.

## Interface
Parameters:
- `DATA_W`, 16, datapath width; matches the ALU `A`/`B`/`C` width.
- `NREGS`, 16, register count; address width is `$clog2(NREGS)` = 4.
- `FLAG_W`, 5, flag vector width; bit order is [4]=Z, [3]=C, [2]=F, [1]=N, [0]=L.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result/flags on this cycle are a real operation.
- `alu_ready`  out  1  stage accepts a new operation; equals `!stall`.
- `stall`  in  1  pipeline hold from control.
- `alu_result`  in  DATA_W  ALU output `C`.
- `alu_flags`  in  FLAG_W  ALU `Flags`.
- `dest_reg`  in  4  destination register index.
- `reg_we`  in  1  write the result into the register file (0 for CMP/CMPU/NOP).
- `flag_mask`  in  FLAG_W  per-bit PSR update enable for this operation.
- `rd_addr_a`  in  4  read port A address.
- `rd_addr_b`  in  4  read port B address.
- `rd_data_a`  out  DATA_W  read port A data, combinational.
- `rd_data_b`  out  DATA_W  read port B data, combinational.
- `psr`  out  FLAG_W  architectural flags, same bit order as `alu_flags`.
- `wb_busy`  out  1  the stage register holds an uncommitted operation.

## Operation
- The stage register holds: valid, data, addr, we, flags, mask.
- Capture: on an edge where `alu_valid && !stall`, load the stage register with valid=1 and the input fields.
- Commit: on every edge where stage valid=1:
  - if `we`, write `regfile[addr] <= data`;
  - PSR update is `psr <= (psr & ~mask) | (flags & mask)`.
- Capture and commit on the same edge are normal back-to-back operation. The old entry commits and the new entry loads.
- On an edge with stage valid=1 and no capture (`!alu_valid` or `stall`), valid clears to 0. Each entry commits exactly once.
- `stall` blocks capture only; an entry already in the stage still commits.
- `alu_valid` while `stall=1` is dropped, and `alu_ready=0` signals the drop. Upstream holds the operation until `alu_ready=1`.
- An entry with `reg_we=0` and `flag_mask=0` is a NOP. It occupies the stage and changes nothing.
- All 16 registers are writable; there is no hardwired zero register.
- Read ports: `rd_data_x = regfile[rd_addr_x]` (bypass rules in Configuration).
- `wb_busy` = stage valid.

## Timing
- Reset (async, `rst_n=0`): all registers are 0, PSR is 0 and stage valid is 0. All outputs are 0 except `alu_ready = !stall`. Reset mid-operation discards the staged entry with no commit.
- Latency: an operation presented in cycle N is captured at edge N and architecturally visible (register file and PSR) after edge N+1.
- Throughput: one operation per cycle while `stall=0`.
- The `psr` output reflects committed state only and is never bypassed.

## Configuration
- `ALU_WB_BYPASS_EN` defined:
  - A read port whose address equals the staged addr, with stage valid=1 and we=1, returns the staged data instead of the register file.
  - A dependent operation can issue in cycle N+1.
- Undefined:
  - Read ports return the register file only.
  - Control must insert one bubble between a write and a dependent read.
  - Read results are then correct from cycle N+2.

## Structure
- Shared package `alu_pkg`:
  - `DATA_W` and `FLAG_W`;
  - flag bit index constants `FLAG_Z`=4, `FLAG_C`=3, `FLAG_F`=2, `FLAG_N`=1, `FLAG_L`=0;
  - ALU opcode constants (ADD, ADDU, SUB, CMP, CMPU), used by control to derive `reg_we` and `flag_mask`.
- Sub-module `regfile_2r1w`: 16 × 16-bit array, async-reset to 0, one write port and two combinational read ports. The bypass mux and PSR live in `alu_writeback`.

## Test plan
- Reset:
  - Drive `rst_n=0` mid-stream with a staged write of 0x1234 to r3.
  - Response: after release, r3 = 0x0000, `psr`=00000, `wb_busy`=0.
- ADD writeback:
  - Present result 0x8000, flags 00110, `dest_reg`=r5, `reg_we`=1, mask 11111.
  - Response: after edge N+1, `rd_data_a`(r5) = 0x8000 and `psr` = 00110.
- CMP flags only:
  - r2 = 0xAAAA beforehand, then present result 0x1111, `dest_reg`=r2, `reg_we`=0, flags 00011, mask 10011.
  - Response: r2 stays 0xAAAA; `psr` bits Z, N, L = 0, 1, 1; C and F unchanged.
- Back-to-back:
  - Write 0x0001 to r1 in cycle N, then 0x0002 to r1 in cycle N+1.
  - Response: r1 = 0x0002 after edge N+2, with no lost commit.
- Bypass:
  - With `ALU_WB_BYPASS_EN`, write 0xBEEF to r7 in cycle N and read r7 on port B in cycle N+1. Response: 0xBEEF.
  - Without the macro, the same sequence returns the old r7 value in N+1 and 0xBEEF in N+2.
- Stall:
  - Hold `stall=1` with `alu_valid=1` for 3 cycles, carrying a write of 0x00FF to r4.
  - Response: `alu_ready`=0 and r4 is unchanged. A previously staged entry commits exactly once, and `wb_busy` falls after that commit.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU/writeback definitions: datapath widths, PSR flag bit positions,
// opcodes, and the control-side helpers that derive reg_we and flag_mask.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int FLAG_W = 5;
  localparam int NREGS  = 16;
  localparam int REG_AW = $clog2(NREGS);

  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_L = 0;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [FLAG_W-1:0] flags_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_ADDU = 3'd2,
    OP_SUB  = 3'd3,
    OP_CMP  = 3'd4,
    OP_CMPU = 3'd5
  } alu_op_e;

  // Compare-class operations only touch the PSR, never the register file.
  function automatic logic op_writes_reg(alu_op_e op);
    return (op == OP_ADD) || (op == OP_ADDU) || (op == OP_SUB);
  endfunction

  function automatic flags_t op_flag_mask(alu_op_e op);
    flags_t m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB: m = '1;
      OP_ADDU: begin
        m[FLAG_Z] = 1'b1;
        m[FLAG_C] = 1'b1;
      end
      OP_CMP, OP_CMPU: begin
        m[FLAG_Z] = 1'b1;
        m[FLAG_N] = 1'b1;
        m[FLAG_L] = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-to-writeback handshake bundle: result, flags, destination and update
// enables travelling with alu_valid, and alu_ready flowing back upstream.
interface alu_writeback_if;
  import alu_pkg::*;

  logic      alu_valid;
  logic      alu_ready;
  data_t     alu_result;
  flags_t    alu_flags;
  reg_addr_t dest_reg;
  logic      reg_we;
  flags_t    flag_mask;

  modport master (
    output alu_valid,
    output alu_result,
    output alu_flags,
    output dest_reg,
    output reg_we,
    output flag_mask,
    input  alu_ready
  );

  modport slave (
    input  alu_valid,
    input  alu_result,
    input  alu_flags,
    input  dest_reg,
    input  reg_we,
    input  flag_mask,
    output alu_ready
  );

endinterface

// File: rtl/regfile_2r1w.sv
// General-purpose register file: NREGS x DATA_W, one synchronous write port,
// two combinational read ports, every entry cleared by async reset.
module regfile_2r1w
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int NREGS  = alu_pkg::NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] regs [NREGS];

  // No hardwired zero register: every index is writable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage after the ALU: one stage register, commit into the register
// file and PSR. Optional read-port bypass of the staged write: ALU_WB_BYPASS_EN.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int NREGS  = alu_pkg::NREGS,
  parameter int FLAG_W = alu_pkg::FLAG_W,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  alu_writeback_if.slave        alu,
  input  logic [AW-1:0]         rd_addr_a,
  input  logic [AW-1:0]         rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_a,
  output logic [DATA_W-1:0]     rd_data_b,
  output logic [FLAG_W-1:0]     psr,
  output logic                  wb_busy
);

  logic              stg_valid;
  logic [DATA_W-1:0] stg_data;
  logic [AW-1:0]     stg_addr;
  logic              stg_we;
  logic [FLAG_W-1:0] stg_flags;
  logic [FLAG_W-1:0] stg_mask;
  logic              capture;
  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;

  assign capture       = alu.alu_valid && !stall;
  assign alu.alu_ready = !stall;
  assign wb_busy       = stg_valid;

  // Valid follows capture every edge, so a held entry commits exactly once
  // even while stall blocks new work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= 1'b0;
      stg_data  <= '0;
      stg_addr  <= '0;
      stg_we    <= 1'b0;
      stg_flags <= '0;
      stg_mask  <= '0;
    end else begin
      stg_valid <= capture;
      if (capture) begin
        stg_data  <= alu.alu_result;
        stg_addr  <= alu.dest_reg;
        stg_we    <= alu.reg_we;
        stg_flags <= alu.alu_flags;
        stg_mask  <= alu.flag_mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psr <= '0;
    end else if (stg_valid) begin
      psr <= (psr & ~stg_mask) | (stg_flags & stg_mask);
    end
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (stg_valid && stg_we),
    .wr_addr   (stg_addr),
    .wr_data   (stg_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rf_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rf_data_b)
  );

`ifdef ALU_WB_BYPASS_EN
  logic hit_a;
  logic hit_b;

  // Forward the not-yet-committed write so a dependent op can issue next cycle.
  assign hit_a     = stg_valid && stg_we && (stg_addr == rd_addr_a);
  assign hit_b     = stg_valid && stg_we && (stg_addr == rd_addr_b);
  assign rd_data_a = hit_a ? stg_data : rf_data_a;
  assign rd_data_b = hit_b ? stg_data : rf_data_b;
`else
  assign rd_data_a = rf_data_a;
  assign rd_data_b = rf_data_b;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: expected commits are queued at issue
// and checked against the read ports and PSR when the stage commits them.
module tb_alu_writeback;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic [4:0]  psr;
  logic        wb_busy;

  alu_writeback_if bus ();

  alu_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .alu       (bus),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .psr       (psr),
    .wb_busy   (wb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic        we;
    logic [15:0] data;
    logic [4:0]  psr_after;
  } sb_entry_t;

  sb_entry_t   sbq[$];
  logic [15:0] mreg [16];
  logic [4:0]  mpsr;
  logic [4:0]  fpsr;
  logic        mstg_valid;
  logic        mstg_we;
  logic [3:0]  mstg_addr;
  logic [15:0] mstg_data;
  logic        cap_valid;
  logic        cap_we;
  logic [3:0]  cap_addr;
  logic [15:0] cap_data;
  int          vec_count = 0;
  int          miss_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [3:0] addr);
`ifdef ALU_WB_BYPASS_EN
    if (mstg_valid && mstg_we && (mstg_addr == addr)) begin
      return mstg_data;
    end
`endif
    return mreg[addr];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      mreg[i] = '0;
    end
    mpsr       = '0;
    fpsr       = '0;
    mstg_valid = 1'b0;
    mstg_we    = 1'b0;
    mstg_addr  = '0;
    mstg_data  = '0;
    cap_valid  = 1'b0;
    cap_we     = 1'b0;
    cap_addr   = '0;
    cap_data   = '0;
    sbq.delete();
  endtask

  // Drive one cycle's worth of upstream inputs; queue the expected commit if captured.
  task automatic applyStimulus(input logic valid, input logic st, input logic [15:0] result,
                               input logic [4:0] flags, input logic [3:0] dest,
                               input logic we, input logic [4:0] mask);
    sb_entry_t e;
    stall          = st;
    bus.alu_valid  = valid;
    bus.alu_result = result;
    bus.alu_flags  = flags;
    bus.dest_reg   = dest;
    bus.reg_we     = we;
    bus.flag_mask  = mask;
    cap_valid      = valid && !st;
    if (cap_valid) begin
      fpsr        = (fpsr & ~mask) | (flags & mask);
      e.addr      = dest;
      e.we        = we;
      e.data      = result;
      e.psr_after = fpsr;
      sbq.push_back(e);
      cap_we   = we;
      cap_addr = dest;
      cap_data = result;
    end
  endtask

  task automatic tick();
    sb_entry_t e;
    logic      committed;
    #1;
    checkOutput("alu_ready", 32'(bus.alu_ready), 32'(!stall));
    @(posedge clk);
    #1;
    committed = 1'b0;
    if (mstg_valid && (sbq.size() != 0)) begin
      e = sbq.pop_front();
      if (e.we) begin
        mreg[e.addr] = e.data;
      end
      mpsr      = e.psr_after;
      committed = 1'b1;
    end
    mstg_valid    = cap_valid;
    mstg_we       = cap_we;
    mstg_addr     = cap_addr;
    mstg_data     = cap_data;
    cap_valid     = 1'b0;
    bus.alu_valid = 1'b0;
    checkOutput("wb_busy", 32'(wb_busy), 32'(mstg_valid));
    checkOutput("psr", 32'(psr), 32'(mpsr));
    if (committed) begin
      rd_addr_a = e.addr;
      #1;
      checkOutput("commit_rd_a", 32'(rd_data_a), 32'(exp_read(e.addr)));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      stall         = 1'b0;
      bus.alu_valid = 1'b0;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] r;
    logic [4:0]  f;
    logic [4:0]  m;
    logic [3:0]  d;
    logic        v;
    logic        s;
    logic        w;

    rst_n          = 1'b0;
    stall          = 1'b0;
    rd_addr_a      = '0;
    rd_addr_b      = '0;
    bus.alu_valid  = 1'b0;
    bus.alu_result = '0;
    bus.alu_flags  = '0;
    bus.dest_reg   = '0;
    bus.reg_we     = 1'b0;
    bus.flag_mask  = '0;
    clear_model();

    #12;
    checkOutput("rst_psr", 32'(psr), 32'd0);
    checkOutput("rst_busy", 32'(wb_busy), 32'd0);
    checkOutput("rst_ready", 32'(bus.alu_ready), 32'd1);
    checkOutput("rst_rd_a", 32'(rd_data_a), 32'd0);
    checkOutput("rst_rd_b", 32'(rd_data_b), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ADD writeback into r5 with full flag update
    applyStimulus(1'b1, 1'b0, 16'h8000, 5'b00110, 4'd5, 1'b1, 5'b11111);
    tick();
    tick();
    rd_addr_a = 4'd5;
    #1;
    checkOutput("add_r5", 32'(rd_data_a), 32'h8000);
    checkOutput("add_psr", 32'(psr), 32'h06);

    // CMP touches only Z/N/L and leaves r2 alone
    applyStimulus(1'b1, 1'b0, 16'hAAAA, 5'b00000, 4'd2, 1'b1, 5'b00000);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h1111, 5'b00011, 4'd2, 1'b0, 5'b10011);
    tick();
    tick();
    rd_addr_a = 4'd2;
    #1;
    checkOutput("cmp_r2", 32'(rd_data_a), 32'hAAAA);
    checkOutput("cmp_psr", 32'(psr), 32'h07);

    // Back-to-back writes to r1
    applyStimulus(1'b1, 1'b0, 16'h0001, 5'b00000, 4'd1, 1'b1, 5'b00000);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0002, 5'b00000, 4'd1, 1'b1, 5'b00000);
    tick();
    tick();
    rd_addr_a = 4'd1;
    #1;
    checkOutput("b2b_r1", 32'(rd_data_a), 32'h0002);

    // Dependent read of r7 one and two cycles after the write
    applyStimulus(1'b1, 1'b0, 16'h1357, 5'b00000, 4'd7, 1'b1, 5'b00000);
    tick();
    idle(1);
    applyStimulus(1'b1, 1'b0, 16'hBEEF, 5'b00000, 4'd7, 1'b1, 5'b00000);
    tick();
    rd_addr_b = 4'd7;
    #1;
`ifdef ALU_WB_BYPASS_EN
    checkOutput("byp_n1", 32'(rd_data_b), 32'hBEEF);
`else
    checkOutput("byp_n1", 32'(rd_data_b), 32'h1357);
`endif
    idle(1);
    rd_addr_b = 4'd7;
    #1;
    checkOutput("byp_n2", 32'(rd_data_b), 32'hBEEF);

    // Stall for three cycles with a write to r4 held upstream
    applyStimulus(1'b1, 1'b0, 16'h0055, 5'b10000, 4'd6, 1'b1, 5'b10000);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 16'h00FF, 5'b01000, 4'd4, 1'b1, 5'b11111);
      tick();
    end
    checkOutput("stall_busy", 32'(wb_busy), 32'd0);
    rd_addr_b = 4'd4;
    #1;
    checkOutput("stall_r4", 32'(rd_data_b), 32'h0000);
    rd_addr_b = 4'd6;
    #1;
    checkOutput("stall_r6", 32'(rd_data_b), 32'h0055);
    idle(1);

    // Mixed traffic with random stalls and bubbles
    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0);
      w = 1'($urandom_range(0, 1));
      r = 16'($urandom);
      f = 5'($urandom);
      m = 5'($urandom);
      d = 4'($urandom_range(0, 15));
      applyStimulus(v, s, r, f, d, w, m);
      tick();
      rd_addr_b = 4'($urandom_range(0, 15));
      #1;
      checkOutput("rand_rd_b", 32'(rd_data_b), 32'(exp_read(rd_addr_b)));
    end
    idle(2);

    // Reset with a staged write to r3 that must never commit
    applyStimulus(1'b1, 1'b0, 16'h1234, 5'b11111, 4'd3, 1'b1, 5'b11111);
    tick();
    stall         = 1'b0;
    bus.alu_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_model();
    rd_addr_a = 4'd3;
    #1;
    checkOutput("rst2_r3", 32'(rd_data_a), 32'h0000);
    checkOutput("rst2_psr", 32'(psr), 32'd0);
    checkOutput("rst2_busy", 32'(wb_busy), 32'd0);
    checkOutput("rst2_ready", 32'(bus.alu_ready), 32'd1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
